serial_subtractor: RTL and testbench

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

---
 rtl/serial_subtractor.sv | 101 ++++++++++
 tb/tb_serial_subtractor.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes a - b - bin LSB first, one bit per cycle.
// Ports: clk, rst (sync, high), start/a/b/bin in; busy, done, diff, bout out.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  state_t           state_nx;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res;
  logic [WIDTH-1:0] res_nx;
  logic             br;
  logic             br_nx;
  logic             d;
  logic [CW-1:0]    cnt;
  logic             last;

  always_comb begin
    d      = a_sh[0] ^ b_sh[0] ^ br;
    br_nx  = (~a_sh[0] & b_sh[0])
           | (~(a_sh[0] ^ b_sh[0]) & br);
    // Result fills from the MSB end so the
    // final bit lands it fully aligned.
    res_nx = res >> 1;
    res_nx[WIDTH-1] = d;
    last   = (cnt == LAST);
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (start) state_nx = RUN;
      RUN:  if (last) state_nx = DONE;
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      a_sh  <= '0;
      b_sh  <= '0;
      res   <= '0;
      br    <= 1'b0;
      cnt   <= '0;
      diff  <= '0;
      bout  <= 1'b0;
    end else begin
      state <= state_nx;
      unique case (state)
        IDLE: begin
          if (start) begin
            a_sh <= a;
            b_sh <= b;
            br   <= bin;
            res  <= '0;
            cnt  <= '0;
          end
        end
        RUN: begin
          a_sh <= a_sh >> 1;
          b_sh <= b_sh >> 1;
          br   <= br_nx;
          res  <= res_nx;
          cnt  <= cnt + CW'(1);
          if (last) begin
            diff <= res_nx;
            bout <= br_nx;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor at WIDTH=8 and WIDTH=1.
// Ports driven from one linear initial block; results checked inline.
module tb_serial_subtractor;

  logic       clk;
  logic       rst;
  logic       start8;
  logic [7:0] a8;
  logic [7:0] b8;
  logic       bin8;
  logic       busy8;
  logic       done8;
  logic [7:0] diff8;
  logic       bout8;
  logic       start1;
  logic [0:0] a1;
  logic [0:0] b1;
  logic       bin1;
  logic       busy1;
  logic       done1;
  logic [0:0] diff1;
  logic       bout1;

  int checks = 0;
  int errors = 0;

  serial_subtractor #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst), .start(start8),
    .a(a8), .b(b8), .bin(bin8),
    .busy(busy8), .done(done8),
    .diff(diff8), .bout(bout8)
  );

  serial_subtractor #(.WIDTH(1)) u1 (
    .clk(clk), .rst(rst), .start(start1),
    .a(a1), .b(b1), .bin(bin1),
    .busy(busy1), .done(done1),
    .diff(diff1), .bout(bout1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic op8(input string tag,
                     input logic [7:0] av,
                     input logic [7:0] bv,
                     input logic bi,
                     input int glitch_at,
                     input logic [7:0] ed,
                     input logic eb);
    int n;
    int nd;
    int dat;
    bit stable;
    logic [7:0] prev;
    prev   = diff8;
    start8 = 1'b1;
    a8     = av;
    b8     = bv;
    bin8   = bi;
    tick();
    start8 = 1'b0;
    a8     = ~av;
    b8     = ~bv;
    bin8   = ~bi;
    n      = 0;
    nd     = 0;
    dat    = -1;
    stable = 1'b1;
    while (busy8 && n < 30) begin
      if (n == glitch_at) begin
        start8 = 1'b1;
        a8     = 8'hFF;
        b8     = 8'h00;
      end else begin
        start8 = 1'b0;
      end
      if (done8) begin
        nd++;
        dat = n;
      end else if (diff8 !== prev) begin
        stable = 1'b0;
      end
      n++;
      tick();
    end
    start8 = 1'b0;
    chk({tag, " busy_cycles"}, 64'(n), 64'd9);
    chk({tag, " done_count"}, 64'(nd), 64'd1);
    chk({tag, " done_at"}, 64'(dat), 64'd8);
    chk({tag, " diff_hold"}, 64'(stable), 64'd1);
    chk({tag, " diff"}, 64'(diff8), 64'(ed));
    chk({tag, " bout"}, 64'(bout8), 64'(eb));
    n = 0;
    repeat (3) begin
      tick();
      if (busy8) n++;
    end
    chk({tag, " idle_after"}, 64'(n), 64'd0);
  endtask

  initial begin
    int n;
    int pulses;
    int last_k;
    bit stable;
    bit seen;
    logic [7:0] tbl_d;
    logic [7:0] tbl_b;
    logic [2:0] v;

    rst    = 1'b1;
    start8 = 1'b0;
    a8     = '0;
    b8     = '0;
    bin8   = 1'b0;
    start1 = 1'b0;
    a1     = '0;
    b1     = '0;
    bin1   = 1'b0;
    repeat (2) tick();
    chk("rst busy8", 64'(busy8), 64'd0);
    chk("rst done8", 64'(done8), 64'd0);
    chk("rst diff8", 64'(diff8), 64'd0);
    chk("rst bout8", 64'(bout8), 64'd0);
    chk("rst busy1", 64'(busy1), 64'd0);
    chk("rst diff1", 64'(diff1), 64'd0);
    rst = 1'b0;
    tick();

    op8("5A-3C", 8'h5A, 8'h3C, 1'b0, -1, 8'h1E, 1'b0);
    op8("00-01", 8'h00, 8'h01, 1'b0, -1, 8'hFF, 1'b1);
    op8("80-7F-1", 8'h80, 8'h7F, 1'b1, -1, 8'h00, 1'b0);
    op8("ignore", 8'h10, 8'h01, 1'b0, 3, 8'h0F, 1'b0);

    start8 = 1'b1;
    a8     = 8'h10;
    b8     = 8'h01;
    bin8   = 1'b0;
    tick();
    start8 = 1'b0;
    repeat (4) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst busy", 64'(busy8), 64'd0);
    chk("midrst done", 64'(done8), 64'd0);
    chk("midrst diff", 64'(diff8), 64'd0);
    chk("midrst bout", 64'(bout8), 64'd0);
    seen = 1'b0;
    repeat (12) begin
      tick();
      if (done8 || busy8) seen = 1'b1;
    end
    chk("midrst quiet", 64'(seen), 64'd0);
    op8("03-05", 8'h03, 8'h05, 1'b0, -1, 8'hFE, 1'b1);

    start8 = 1'b1;
    a8     = 8'hC8;
    b8     = 8'h64;
    bin8   = 1'b0;
    tick();
    pulses = 0;
    last_k = -1;
    stable = 1'b1;
    for (int k = 0; k < 45; k++) begin
      if (done8) begin
        pulses++;
        if (last_k >= 0)
          chk("stream gap", 64'(k - last_k), 64'd10);
        chk("stream diff", 64'(diff8), 64'h64);
        chk("stream bout", 64'(bout8), 64'd0);
        last_k = k;
      end else if (pulses > 0 && diff8 !== 8'h64) begin
        stable = 1'b0;
      end
      tick();
    end
    start8 = 1'b0;
    chk("stream pulses", 64'(pulses), 64'd4);
    chk("stream hold", 64'(stable), 64'd1);
    n = 0;
    while (busy8 && n < 20) begin
      n++;
      tick();
    end
    chk("stream drain", 64'(busy8), 64'd0);

    tbl_d = 8'b1001_0110;
    tbl_b = 8'b1000_1110;
    for (int i = 0; i < 8; i++) begin
      v      = 3'(i);
      start1 = 1'b1;
      a1     = v[2];
      b1     = v[1];
      bin1   = v[0];
      tick();
      start1 = 1'b0;
      a1     = ~v[2];
      b1     = ~v[1];
      bin1   = ~v[0];
      chk($sformatf("w1 %0d run_done", i),
          64'(done1), 64'd0);
      chk($sformatf("w1 %0d run_busy", i),
          64'(busy1), 64'd1);
      tick();
      chk($sformatf("w1 %0d done", i),
          64'(done1), 64'd1);
      chk($sformatf("w1 %0d diff", i),
          64'(diff1), 64'(tbl_d[i]));
      chk($sformatf("w1 %0d bout", i),
          64'(bout1), 64'(tbl_b[i]));
      tick();
      chk($sformatf("w1 %0d idle", i),
          64'(busy1), 64'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
